mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the CPU's single memory port between the instruction-fetch requester and the load/store requester of the datapath. It arbitrates and captures the winning request, then drives it to memory. It tracks the one outstanding transaction and routes the response back to its owner. Data accesses have priority, and a streak limit bounds how long fetch can be starved. The block sits between the datapath's fetch and LSU ports and the memory interface.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_DATA_STREAK, 4, consecutive data grants allowed while fetch is waiting before fetch wins once (≥1)

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request, held with if_addr until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch request accepted by memory
- if_rvalid  out  1  fetch response valid
- if_rdata  out  DATA_W  fetch response data
- d_req  in  1  data request, held with attributes until d_gnt
- d_we  in  1  1 = store
- d_be  in  DATA_W/8  byte enables
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data request accepted by memory
- d_rvalid  out  1  data response valid (load data or store ack)
- d_rdata  out  DATA_W  load data
- mem_req  out  1  memory request, held until mem_gnt
- mem_we, mem_be, mem_addr, mem_wdata  out  1/DATA_W/8/ADDR_W/DATA_W  captured request attributes
- mem_gnt  in  1  memory accepts request
- mem_rvalid  in  1  memory response, ≥1 cycle after mem_gnt, once per transaction
- mem_rdata  in  DATA_W  response data

## Operation
- States: ARB_IDLE, ARB_REQ, ARB_WAIT.
- Arbitration point:
  - every ARB_IDLE cycle;
  - the ARB_WAIT cycle in which mem_rvalid=1.
- At an arbitration point:
  - Neither request pending: go to ARB_IDLE.
  - Otherwise: capture the winner's attributes and owner into registers, then go to ARB_REQ.
- Winner selection:
  - d_req only: data wins.
  - if_req only: fetch wins.
  - Both pending and streak < MAX_DATA_STREAK: data wins and streak increments.
  - Both pending and streak == MAX_DATA_STREAK: fetch wins.
- Streak clears on any fetch win. It is unchanged when data wins uncontested.
- ARB_REQ:
  - mem_req=1 and mem_* come from the capture registers.
  - On mem_gnt, pulse the owner's gnt (combinational, same cycle) and go to ARB_WAIT.
- ARB_WAIT:
  - mem_req=0.
  - On mem_rvalid, drive the owner's rvalid=1 and rdata=mem_rdata the same cycle, then arbitrate.
  - The just-served requester is eligible again.
- The non-owner's rvalid=0 and rdata=0 at all times.
- mem_rvalid outside ARB_WAIT is ignored.
- Stores return an ack through d_rvalid; d_rdata carries mem_rdata and the datapath ignores it.

## Timing
- Reset (async assert, sync-released use):
  - state=ARB_IDLE, streak=0, capture registers 0;
  - all outputs 0.
- Reset mid-transaction: the transaction is abandoned and no gnt/rvalid is emitted afterward. The memory is reset with the CPU.
- Latency:
  - Request seen in IDLE at cycle N: mem_req at N+1; earliest gnt at N+1; earliest rvalid at N+2.
  - Back-to-back throughput is 2 cycles/transaction: the next mem_req is in the cycle after rvalid.
- mem_gnt stall: mem_req and attributes stay constant until gnt.
- Requesters must not drop req or change attributes before gnt. The bench asserts this, and the design does not recover from it.
- Streak counter width: $clog2(MAX_DATA_STREAK+1). It saturates by construction at MAX_DATA_STREAK.

## Structure
- Shared package mem_defs:
  - arb_state_e {ARB_IDLE, ARB_REQ, ARB_WAIT};
  - owner_e {OWN_IF, OWN_D};
  - packed struct mem_req_t {we, be, addr, wdata}.
- Sub-module mem_arb_pick:
  - holds the streak counter;
  - inputs if_req, d_req, arb_en;
  - outputs winner owner_e and valid.
- mem_arbiter holds the FSM, capture register and response routing. The cpu top instantiates it between datapath and memory.

## Test plan
- Fetch alone, mem_gnt immediate, rvalid 1 cycle later, rdata=0xDEADBEEF -> if_gnt at N+1, if_rvalid at N+2 with if_rdata=0xDEADBEEF; d_rvalid stays 0.
- if_req and d_req held continuously, memory zero-wait -> grant order D,D,D,D,IF,D,D,D,D,IF with MAX_DATA_STREAK=4.
- Store d_we=1, d_be=4'b0011, addr 0x100, wdata 0x1234, mem_gnt delayed 3 cycles -> mem_req high 4 cycles with constant attributes, d_gnt on 4th, then d_rvalid on ack.
- rvalid cycle with new d_req pending -> mem_req for the new request in the very next cycle (2-cycle throughput).
- rst_n asserted in ARB_WAIT, then mem_rvalid pulsed after release -> no if_rvalid/d_rvalid, state ARB_IDLE, all outputs 0.
- Spurious mem_rvalid in ARB_IDLE -> ignored, no rvalid to either requester.

Source files
------------

// File: rtl/mem_defs.sv
// Shared types for the CPU memory-port arbiter: FSM states, request owner
// and the captured memory request.
package mem_defs;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_BE_W   = MEM_DATA_W / 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  typedef struct packed {
    logic                  we;
    logic [MEM_BE_W-1:0]   be;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Fetch/data winner selection. Data has priority, but after MAX_DATA_STREAK
// contested data wins in a row the waiting fetch wins once.
module mem_arb_pick
  import mem_defs::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   if_req,
  input  logic   d_req,
  input  logic   arb_en,
  output owner_e winner,
  output logic   valid
);

  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

  logic [SW-1:0] streak_q, streak_d;

  // Only contested data wins advance the streak, so it never exceeds STREAK_MAX.
  always_comb begin
    valid    = if_req | d_req;
    winner   = OWN_IF;
    streak_d = streak_q;
    if (d_req && (!if_req || (streak_q < STREAK_MAX))) begin
      winner = OWN_D;
    end else begin
      winner = OWN_IF;
    end
    if (arb_en && valid) begin
      if (winner == OWN_IF) begin
        streak_d = {SW{1'b0}};
      end else if (if_req) begin
        streak_d = streak_q + SW'(1);
      end else begin
        streak_d = streak_q;
      end
    end else begin
      streak_d = streak_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q <= {SW{1'b0}};
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single memory port between instruction fetch and load/store:
// arbitrates, holds one captured request until granted, routes the response.
module mem_arbiter
  import mem_defs::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  arb_state_e state_q, state_d;
  owner_e     owner_q, owner_d;
  mem_req_t   cap_q, cap_d;
  owner_e     pick_winner;
  logic       pick_valid;
  logic       arb_en;

  mem_arb_pick #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_pick (
    .clk   (clk),
    .rst_n (rst_n),
    .if_req(if_req),
    .d_req (d_req),
    .arb_en(arb_en),
    .winner(pick_winner),
    .valid (pick_valid)
  );

  // Next state, capture and response routing; gnt/rvalid are same-cycle so a
  // new request can follow an rvalid immediately.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cap_d     = cap_q;
    arb_en    = 1'b0;
    mem_req   = 1'b0;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    if_rdata  = {DATA_W{1'b0}};
    d_rdata   = {DATA_W{1'b0}};
    case (state_q)
      ARB_IDLE: begin
        arb_en = 1'b1;
      end
      ARB_REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) begin
          if (owner_q == OWN_D) begin
            d_gnt = 1'b1;
          end else begin
            if_gnt = 1'b1;
          end
          state_d = ARB_WAIT;
        end else begin
          state_d = ARB_REQ;
        end
      end
      ARB_WAIT: begin
        if (mem_rvalid) begin
          arb_en = 1'b1;
          if (owner_q == OWN_D) begin
            d_rvalid = 1'b1;
            d_rdata  = mem_rdata;
          end else begin
            if_rvalid = 1'b1;
            if_rdata  = mem_rdata;
          end
        end else begin
          state_d = ARB_WAIT;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
    // Fetch carries only an address and always reads the full word.
    if (arb_en) begin
      if (pick_valid) begin
        state_d = ARB_REQ;
        owner_d = pick_winner;
        if (pick_winner == OWN_D) begin
          cap_d.we    = d_we;
          cap_d.be    = MEM_BE_W'(d_be);
          cap_d.addr  = MEM_ADDR_W'(d_addr);
          cap_d.wdata = MEM_DATA_W'(d_wdata);
        end else begin
          cap_d.we    = 1'b0;
          cap_d.be    = {MEM_BE_W{1'b1}};
          cap_d.addr  = MEM_ADDR_W'(if_addr);
          cap_d.wdata = {MEM_DATA_W{1'b0}};
        end
      end else begin
        state_d = ARB_IDLE;
      end
    end else begin
      owner_d = owner_q;
    end
  end

  // State, owner and capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_IF;
      cap_q   <= '{we: 1'b0, be: {MEM_BE_W{1'b0}}, addr: {MEM_ADDR_W{1'b0}},
                   wdata: {MEM_DATA_W{1'b0}}};
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cap_q   <= cap_d;
    end
  end

  assign mem_we    = cap_q.we;
  assign mem_be    = (DATA_W/8)'(cap_q.be);
  assign mem_addr  = ADDR_W'(cap_q.addr);
  assign mem_wdata = DATA_W'(cap_q.wdata);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a transaction-level
// reference model (one outstanding request, streak counted as an integer).
module tb_mem_arbiter;

  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DATA_STREAK(MAXS)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  // reference model: the single outstanding transaction
  bit          m_busy, m_issued, m_own_d;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata;
  int          m_streak;
  bit          x_ifgnt, x_dgnt, x_rv;

  logic        o_mem_req, o_if_gnt, o_d_gnt, o_if_rv, o_d_rv;
  logic [31:0] o_if_rd, o_d_rd;
  bit          g_obs[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_issued = 1'b0; m_own_d = 1'b0;
    m_we = 1'b0; m_be = 4'h0; m_addr = 32'h0; m_wdata = 32'h0;
    m_streak = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, 128'({mem_req, if_gnt, d_gnt, if_rvalid, d_rvalid, if_rdata, d_rdata,
                   mem_we, mem_be, mem_addr, mem_wdata}), 128'(0));
  endtask

  // One clock cycle: drive inputs, sample and check against the model, advance.
  task automatic cyc(input logic ireq, input logic [31:0] iaddr,
                     input logic dreq, input logic dwe, input logic [3:0] dbe,
                     input logic [31:0] daddr, input logic [31:0] dwdata,
                     input logic mg, input logic mrv, input logic [31:0] mrd);
    bit e_mreq, win_d;
    if_req = ireq; if_addr = iaddr;
    d_req = dreq; d_we = dwe; d_be = dbe; d_addr = daddr; d_wdata = dwdata;
    mem_gnt = mg; mem_rvalid = mrv; mem_rdata = mrd;
    #4;
    o_mem_req = mem_req; o_if_gnt = if_gnt; o_d_gnt = d_gnt;
    o_if_rv = if_rvalid; o_d_rv = d_rvalid; o_if_rd = if_rdata; o_d_rd = d_rdata;
    if (!rst_n) begin
      model_reset();
      x_ifgnt = 1'b0; x_dgnt = 1'b0; x_rv = 1'b0;
      chk("in_reset", 128'({mem_req, if_gnt, d_gnt, if_rvalid, d_rvalid, if_rdata, d_rdata}), 128'(0));
    end else begin
      e_mreq  = m_busy && !m_issued;
      x_ifgnt = e_mreq && mg && !m_own_d;
      x_dgnt  = e_mreq && mg && m_own_d;
      x_rv    = m_busy && m_issued && mrv;
      chk("mem_req", 128'(mem_req), 128'(e_mreq));
      chk("if_gnt", 128'(if_gnt), 128'(x_ifgnt));
      chk("d_gnt", 128'(d_gnt), 128'(x_dgnt));
      chk("if_rvalid", 128'(if_rvalid), 128'(x_rv && !m_own_d));
      chk("d_rvalid", 128'(d_rvalid), 128'(x_rv && m_own_d));
      chk("if_rdata", 128'(if_rdata), 128'((x_rv && !m_own_d) ? mrd : 32'h0));
      chk("d_rdata", 128'(d_rdata), 128'((x_rv && m_own_d) ? mrd : 32'h0));
      if (e_mreq)
        chk("mem_attr", 128'({mem_we, mem_be, mem_addr, mem_wdata}),
            128'({m_we, m_be, m_addr, m_wdata}));
      if (if_gnt) g_obs.push_back(1'b0);
      if (d_gnt) g_obs.push_back(1'b1);
      if (x_ifgnt || x_dgnt) m_issued = 1'b1;
      if (!m_busy || x_rv) begin
        if (!ireq && !dreq) begin
          m_busy = 1'b0;
        end else begin
          if (ireq && dreq) begin
            if (m_streak < MAXS) begin win_d = 1'b1; m_streak++; end
            else begin win_d = 1'b0; m_streak = 0; end
          end else if (dreq) begin
            win_d = 1'b1;
          end else begin
            win_d = 1'b0; m_streak = 0;
          end
          m_busy = 1'b1; m_issued = 1'b0; m_own_d = win_d;
          if (win_d) begin
            m_we = dwe; m_be = dbe; m_addr = daddr; m_wdata = dwdata;
          end else begin
            m_we = 1'b0; m_be = 4'hF; m_addr = iaddr; m_wdata = 32'h0;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit          exp_order[10];
    bit          mo, ia, da, rwe, mg_r, mrv_r;
    logic [31:0] ra_i, ra_da, ra_dw;
    logic [3:0]  rbe;
    int          n;

    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    rst_n = 1'b0;
    model_reset();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_all_zero("reset_outputs");
    rst_n = 1'b1;

    // fetch alone, immediate gnt, rvalid one cycle later
    cyc(1, 32'h40, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("t1_no_req_at_N", 128'(o_mem_req), 128'(0));
    cyc(1, 32'h40, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("t1_if_gnt_N1", 128'(o_if_gnt), 128'(1));
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF);
    chk("t1_if_rvalid_N2", 128'(o_if_rv), 128'(1));
    chk("t1_if_rdata", 128'(o_if_rd), 128'(32'hDEADBEEF));
    chk("t1_d_rvalid_low", 128'(o_d_rv), 128'(0));

    // both requesters held, zero-wait memory: streak-limited grant order
    g_obs.delete();
    mo = 1'b0;
    for (int k = 0; k < 40 && g_obs.size() < 10; k++) begin
      cyc(1, 32'h1000 + k, 1, 0, 4'hF, 32'h2000 + k, 32'h0, 1, mo, 32'(k));
      if (x_ifgnt || x_dgnt) mo = 1'b1;
      else if (x_rv) mo = 1'b0;
    end
    chk("t2_grant_count", 128'(g_obs.size()), 128'(10));
    for (int i = 0; i < 10 && i < g_obs.size(); i++)
      chk($sformatf("t2_order_%0d", i), 128'(g_obs[i]), 128'(exp_order[i]));
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h5);

    // store with mem_gnt stalled three cycles
    cyc(0, 0, 1, 1, 4'b0011, 32'h100, 32'h1234, 0, 0, 0);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 1, 4'b0011, 32'h100, 32'h1234, 1'(i == 3), 0, 0);
      if (o_mem_req) n++;
      if (i == 3) chk("t3_d_gnt_4th", 128'(o_d_gnt), 128'(1));
    end
    chk("t3_req_cycles", 128'(n), 128'(4));
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFE);
    chk("t3_store_ack", 128'(o_d_rv), 128'(1));

    // new data request pending in the rvalid cycle
    cyc(0, 0, 1, 0, 4'hF, 32'h200, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 4'hF, 32'h200, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 4'hF, 32'h204, 0, 0, 1, 32'h11);
    cyc(0, 0, 1, 0, 4'hF, 32'h204, 0, 0, 0, 0);
    chk("t4_b2b_mem_req", 128'(o_mem_req), 128'(1));
    cyc(0, 0, 1, 0, 4'hF, 32'h204, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h22);

    // reset while waiting for the response
    cyc(1, 32'h300, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 32'h300, 0, 0, 0, 0, 0, 1, 0, 0);
    if_req = 1'b0; mem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_all_zero("t5_async_reset");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77);
    chk("t5_no_if_rvalid", 128'(o_if_rv), 128'(0));
    chk("t5_no_d_rvalid", 128'(o_d_rv), 128'(0));
    chk_all_zero("t5_idle_outputs");

    // spurious response in idle while a new data request arrives
    cyc(0, 0, 1, 0, 4'hF, 32'h400, 0, 0, 1, 32'h99);
    chk("t6_spurious_d", 128'(o_d_rv), 128'(0));
    chk("t6_spurious_if", 128'(o_if_rv), 128'(0));
    cyc(0, 0, 1, 0, 4'hF, 32'h400, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h33);

    // randomized requesters and memory latency
    ia = 1'b0; da = 1'b0; mo = 1'b0;
    ra_i = 32'h0; ra_da = 32'h0; ra_dw = 32'h0; rbe = 4'h0; rwe = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if (!ia && $urandom_range(0, 2) != 0) begin ia = 1'b1; ra_i = $urandom; end
      if (!da && $urandom_range(0, 2) != 0) begin
        da = 1'b1; ra_da = $urandom; ra_dw = $urandom;
        rbe = 4'($urandom); rwe = 1'($urandom);
      end
      mg_r  = 1'($urandom_range(0, 1));
      mrv_r = mo ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      cyc(ia, ra_i, da, rwe, rbe, ra_da, ra_dw, mg_r, mrv_r, $urandom);
      if (x_ifgnt) ia = 1'b0;
      if (x_dgnt) da = 1'b0;
      if (x_ifgnt || x_dgnt) mo = 1'b1;
      else if (x_rv) mo = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
